// File: rtl/dice_display_ctrl.sv
// dice_display_ctrl
//   Two-player dice round controller feeding a 7-segment encoder. Each
//   player's roll is latched through a valid/ready handshake. Once both dice
//   are in, the round is evaluated in one cycle and the result is held on the
//   display for HOLD_CYCLES cycles. The 1-2 outcome blinks during that hold.
//   Consecutive doubles are counted before the controller re-arms.
//
// Ports
//   clk, rst_n               : clock, synchronous active-low reset
//   dice1/roll1_valid/ready  : player 1 roll handshake
//   dice2/roll2_valid/ready  : player 2 roll handshake
//   digit, pattern, blank    : encoder controls (0=digit,1=all,2=bars,3=middle)
//   busy                     : evaluating or showing a result
//   round_done               : one-cycle pulse on return to collecting
//   roll_err                 : one-cycle pulse for an out-of-range roll
//   pasch_cnt                : saturating consecutive-doubles count
module dice_display_ctrl #(
  parameter int DICE_W      = 3,
  parameter int MAX_FACE    = 6,
  parameter int HOLD_CYCLES = 1000,
  parameter int BLINK_HALF  = 250,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DICE_W-1:0] dice1,
  input  logic              roll1_valid,
  output logic              roll1_ready,
  input  logic [DICE_W-1:0] dice2,
  input  logic              roll2_valid,
  output logic              roll2_ready,
  output logic [3:0]        digit,
  output logic [1:0]        pattern,
  output logic              blank,
  output logic              busy,
  output logic              round_done,
  output logic              roll_err,
  output logic [CNT_W-1:0]  pasch_cnt
);

  localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [1:0] PAT_DIGIT = 2'd0;
  localparam logic [1:0] PAT_ALL   = 2'd1;
  localparam logic [1:0] PAT_BARS  = 2'd2;
  localparam logic [1:0] PAT_MID   = 2'd3;

  typedef enum logic [1:0] {COLLECT, EVAL, SHOW} state_t;

  state_t               state_q, state_d;
  logic [DICE_W-1:0]    d1_q, d1_d, d2_q, d2_d;
  logic                 f1_q, f1_d, f2_q, f2_d;
  logic [3:0]           digit_q, digit_d;
  logic [1:0]           pattern_q, pattern_d;
  logic                 blank_q, blank_d;
  logic                 busy_q, busy_d;
  logic                 round_done_q, round_done_d;
  logic                 roll_err_q, roll_err_d;
  logic [CNT_W-1:0]     pasch_q, pasch_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [BLINK_W-1:0]   blink_q, blink_d;
  logic                 ok1, ok2;

  function automatic logic in_range(input logic [DICE_W-1:0] v);
    return (v != '0) && (int'(v) <= MAX_FACE);
  endfunction

  assign roll1_ready = (state_q == COLLECT) && !f1_q;
  assign roll2_ready = (state_q == COLLECT) && !f2_q;
  assign ok1         = in_range(dice1);
  assign ok2         = in_range(dice2);

  always_comb begin
    state_d      = state_q;
    d1_d         = d1_q;
    d2_d         = d2_q;
    f1_d         = f1_q;
    f2_d         = f2_q;
    digit_d      = digit_q;
    pattern_d    = pattern_q;
    blank_d      = blank_q;
    busy_d       = busy_q;
    round_done_d = 1'b0;
    roll_err_d   = 1'b0;
    pasch_d      = pasch_q;
    hold_d       = hold_q;
    blink_d      = blink_q;

    case (state_q)
      COLLECT: begin
        if (roll1_valid && roll1_ready && ok1) begin
          d1_d = dice1;
          f1_d = 1'b1;
        end
        if (roll2_valid && roll2_ready && ok2) begin
          d2_d = dice2;
          f2_d = 1'b1;
        end
        roll_err_d = (roll1_valid && roll1_ready && !ok1) ||
                     (roll2_valid && roll2_ready && !ok2);
        if (f1_d && f2_d) begin
          state_d = EVAL;
          busy_d  = 1'b1;
        end
      end

      EVAL: begin
        state_d = SHOW;
        hold_d  = '0;
        blink_d = '0;
        blank_d = 1'b0;
        if (d1_q == d2_q) begin
          digit_d   = 4'(d1_q);
          pattern_d = PAT_DIGIT;
          pasch_d   = (pasch_q == '1) ? pasch_q : pasch_q + 1'b1;
        end else begin
          digit_d = '0;
          pasch_d = '0;
          if ((d1_q == DICE_W'(1) && d2_q == DICE_W'(2)) ||
              (d1_q == DICE_W'(2) && d2_q == DICE_W'(1)))
            pattern_d = PAT_ALL;
          else if ((d1_q == DICE_W'(3)) || (d2_q == DICE_W'(3)))
            pattern_d = PAT_BARS;  // dice differ here, so at most one is 3
          else
            pattern_d = PAT_MID;
        end
      end

      SHOW: begin
        if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_d      = COLLECT;
          f1_d         = 1'b0;
          f2_d         = 1'b0;
          digit_d      = '0;
          pattern_d    = PAT_MID;
          blank_d      = 1'b0;
          busy_d       = 1'b0;
          round_done_d = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
          // blank is registered, so it toggles on the edge closing each half-period
          if (blink_q == BLINK_W'(BLINK_HALF - 1)) begin
            blink_d = '0;
            blank_d = (pattern_q == PAT_ALL) ? ~blank_q : 1'b0;
          end else begin
            blink_d = blink_q + 1'b1;
          end
        end
      end

      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= COLLECT;
      d1_q         <= '0;
      d2_q         <= '0;
      f1_q         <= 1'b0;
      f2_q         <= 1'b0;
      digit_q      <= '0;
      pattern_q    <= PAT_MID;
      blank_q      <= 1'b0;
      busy_q       <= 1'b0;
      round_done_q <= 1'b0;
      roll_err_q   <= 1'b0;
      pasch_q      <= '0;
      hold_q       <= '0;
      blink_q      <= '0;
    end else begin
      state_q      <= state_d;
      d1_q         <= d1_d;
      d2_q         <= d2_d;
      f1_q         <= f1_d;
      f2_q         <= f2_d;
      digit_q      <= digit_d;
      pattern_q    <= pattern_d;
      blank_q      <= blank_d;
      busy_q       <= busy_d;
      round_done_q <= round_done_d;
      roll_err_q   <= roll_err_d;
      pasch_q      <= pasch_d;
      hold_q       <= hold_d;
      blink_q      <= blink_d;
    end
  end

  assign digit      = digit_q;
  assign pattern    = pattern_q;
  assign blank      = blank_q;
  assign busy       = busy_q;
  assign round_done = round_done_q;
  assign roll_err   = roll_err_q;
  assign pasch_cnt  = pasch_q;

endmodule
